// File: rtl/step_playhead.sv
// step_playhead: 8-step x 8-track pattern sequencer with a horizontally moving
// playhead. Steps advance on vertical-sync edges at a programmable tempo; the
// pattern is edited by single-bit toggles and can be wiped one row per cycle.
module step_playhead #(
    parameter int X0    = 80,
    parameter int PITCH = 64,
    parameter int Y0    = 240,
    parameter int SIZE  = 12
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       run,
    input  logic [5:0] tempo,
    input  logic       clear,
    input  logic       edit_valid,
    output logic       edit_ready,
    input  logic [2:0] edit_step,
    input  logic [2:0] edit_track,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic [7:0] button,
    output logic [2:0] step_idx,
    output logic       step_tick
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [5:0]      frame_q, frame_d;
    logic [2:0]      clr_row_q, clr_row_d;
    logic            fc_q;
    logic [7:0][7:0] pattern_q, pattern_d;
    logic [7:0]      button_q, button_d;
    logic            tick_q, tick_d;
    logic            ready_q, ready_d;

    logic            fc_rise;
    logic [5:0]      frame_lim;
    logic            edit_fire;

    // One registered copy of frame_clk gives a single-cycle rise pulse.
    assign fc_rise   = frame_clk & ~fc_q;
    // Terminal count is max(tempo,1)-1, so tempo 0 behaves like tempo 1.
    assign frame_lim = (tempo == '0) ? '0 : tempo - 6'd1;
    assign edit_fire = edit_valid & ready_q;

    // Next-state, step timer, pattern edit/clear and registered-output values.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        frame_d   = frame_q;
        clr_row_d = clr_row_q;
        tick_d    = 1'b0;
        pattern_d = pattern_q;

        if (edit_fire) begin
            pattern_d[edit_step][edit_track] = ~pattern_q[edit_step][edit_track];
        end

        if (clear) begin
            // Clear wins over everything and always restarts from row 0.
            state_d   = ST_CLEAR;
            clr_row_d = '0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_STOP;
                        step_d  = '0;
                        frame_d = '0;
                    end else if (fc_rise) begin
                        // >= so a tempo lowered mid-count advances on this edge.
                        if (frame_q >= frame_lim) begin
                            frame_d = '0;
                            step_d  = step_q + 3'd1;
                            tick_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + 6'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    pattern_d[clr_row_q] = '0;
                    clr_row_d            = clr_row_q + 3'd1;
                    if (clr_row_q == 3'd7) begin
                        state_d = ST_STOP;
                        step_d  = '0;
                        frame_d = '0;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                    step_d  = '0;
                    frame_d = '0;
                end
            endcase
        end

        ready_d  = (state_d != ST_CLEAR);
        button_d = pattern_q[step_q];
    end

    // State and registered outputs; reset abandons any step or clear in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_STOP;
            step_q    <= '0;
            frame_q   <= '0;
            clr_row_q <= '0;
            fc_q      <= 1'b0;
            pattern_q <= '0;
            button_q  <= '0;
            tick_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            frame_q   <= frame_d;
            clr_row_q <= clr_row_d;
            fc_q      <= frame_clk;
            pattern_q <= pattern_d;
            button_q  <= button_d;
            tick_q    <= tick_d;
            ready_q   <= ready_d;
        end
    end

    assign edit_ready = ready_q;
    assign button     = button_q;
    assign step_idx   = step_q;
    assign step_tick  = tick_q;
    assign BallX      = 10'(X0 + PITCH * int'(step_q));
    assign BallY      = 10'(Y0);
    assign Ball_size  = 10'(SIZE);

endmodule
